mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency memory between two requesters:
  - instruction fetch (IF);
  - data access from the EX/MEM pipeline stage (memRead/memWrite, ALUResult as address, registerFileDataB as write data).
- Sequences each access through a grant FSM and returns read data with a one-cycle valid strobe.
- Drives stall outputs that freeze the IF and EX/MEM pipeline registers while their access is outstanding.

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_port_arbiter_starve_counter.sv | 36 +++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter: state encoding and default widths.
package mem_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      FETCH = 2'd2
   } state_e;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive data grants taken while fetch was waiting.
module starve_counter
   import mem_pkg::*;
#(
   parameter int MAX = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             sat
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign sat = (cnt_q == CNT_W'(MAX));
   assign cnt = cnt_q;

   // clear wins over increment; increment stops at MAX rather than wrapping
   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && !sat)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and
// EX/MEM data accesses, returning data with one-cycle strobes and pipeline stalls.
module mem_port_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              dm_read,
   input  logic              dm_write,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_valid,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   state_e            state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              if_valid_q, if_valid_d;
   logic              dm_valid_q, dm_valid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              stall_if_q, stall_if_d;
   logic              stall_mem_q, stall_mem_d;

   logic              dm_req;
   logic              grant_data, grant_fetch;
   logic              starve_sat;
   logic [CNT_W-1:0]  starve_cnt;

   assign dm_req = dm_read | dm_write;

   // data normally wins; fetch wins when alone or once data has starved it long enough
   assign grant_data  = (state_q == IDLE) && dm_req && !(if_req && starve_sat);
   assign grant_fetch = (state_q == IDLE) && if_req && !grant_data;

   starve_counter #(.MAX(STARVE_MAX)) u_starve (
      .clock   (clock),
      .reset_n (reset_n),
      .inc     (grant_data && if_req),
      .clr     (grant_fetch || (grant_data && !if_req)),
      .cnt     (starve_cnt),
      .sat     (starve_sat)
   );

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_valid_d  = 1'b0;
      dm_valid_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_data) begin
               state_d     = DATA;
               mem_req_d   = 1'b1;
               mem_we_d    = dm_write;
               mem_addr_d  = dm_addr;
               mem_wdata_d = dm_wdata;
            end else if (grant_fetch) begin
               state_d     = FETCH;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = '0;
            end
         end
         DATA: begin
            if (mem_ack) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               dm_valid_d = 1'b1;
               if (!mem_we_q)
                  dm_rdata_d = mem_rdata;
            end
         end
         FETCH: begin
            if (mem_ack) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               if_valid_d = 1'b1;
               if_rdata_d = mem_rdata;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
      stall_mem_d = dm_req && !dm_valid_d;
      stall_if_d  = if_req && !if_valid_d;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_valid_q  <= 1'b0;
         dm_valid_q  <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         stall_if_q  <= 1'b0;
         stall_mem_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_valid_q  <= if_valid_d;
         dm_valid_q  <= dm_valid_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         stall_if_q  <= stall_if_d;
         stall_mem_q <= stall_mem_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_valid  = if_valid_q;
   assign dm_valid  = dm_valid_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign stall_if  = stall_if_q;
   assign stall_mem = stall_mem_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner sequences, and a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int SMAX = 4;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        if_req, dm_read, dm_write, mem_ack;
   logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic        if_valid, dm_valid, stall_if, stall_mem, mem_req, mem_we;

   int n_chk = 0;
   int n_fail = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
      .clock(clock), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_valid(dm_valid), .stall_if(stall_if), .stall_mem(stall_mem),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        ifr;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic [31:0] ack_data;
      logic        exp_we;
      logic        exp_fetch;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ctl"}, {mem_req, mem_we, if_valid, dm_valid, stall_if, stall_mem}, 64'd0);
      chk({tag, "_addr"}, mem_addr, 64'd0);
      chk({tag, "_wdata"}, mem_wdata, 64'd0);
      chk({tag, "_ifrd"}, if_rdata, 64'd0);
      chk({tag, "_dmrd"}, dm_rdata, 64'd0);
      chk({tag, "_state"}, 64'(dut.state_q), 64'd0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      if_req = v.ifr; if_addr = v.addr;
      dm_read = v.rd; dm_write = v.wr; dm_addr = v.addr; dm_wdata = v.wdata;
      step();
      chk($sformatf("v%0d_grant", idx), {mem_req, mem_we}, {1'b1, v.exp_we});
      chk($sformatf("v%0d_addr", idx), mem_addr, v.addr);
      if (v.exp_we) chk($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
      chk($sformatf("v%0d_stall", idx), {stall_if, stall_mem}, {v.ifr, v.rd | v.wr});
      for (int i = 1; i < v.lat; i++) begin
         step();
         chk($sformatf("v%0d_wait", idx), {mem_req, if_valid, dm_valid, stall_if | stall_mem}, 4'b1001);
      end
      mem_ack = 1'b1; mem_rdata = v.ack_data;
      step();
      mem_ack = 1'b0; if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
      chk($sformatf("v%0d_strobe", idx), {if_valid, dm_valid, mem_req, stall_if, stall_mem},
          {v.exp_fetch, !v.exp_fetch, 3'b000});
      chk($sformatf("v%0d_rdata", idx), v.exp_fetch ? if_rdata : dm_rdata, v.exp_rdata);
      step();
      chk($sformatf("v%0d_done", idx), {if_valid, dm_valid, mem_req}, 64'd0);
   endtask

   // reference model state for the randomized phase
   int          m_busy;   // 0 none, 1 data, 2 fetch
   int          m_cnt;
   logic        e_req, e_we, e_ifv, e_dmv, e_sif, e_smem, dreq, take_if;
   logic [31:0] e_addr, e_wdata, e_ifr, e_dmr;

   initial begin
      reset_n = 1'b0; if_req = 0; dm_read = 0; dm_write = 0; mem_ack = 0;
      if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
      #1;
      chk_reset("reset");
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;

      vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h40,  32'h0,        3, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h200, 32'h0,        1, 32'hCAFEF00D, 1'b0, 1'b0, 32'hCAFEF00D};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h100, 32'h12345678, 1, 32'hBAD0BAD0, 1'b1, 1'b0, 32'hCAFEF00D};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h104, 32'h0F0F0F0F, 2, 32'h11111111, 1'b1, 1'b0, 32'hCAFEF00D};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h44,  32'h0,        1, 32'h13579BDF, 1'b0, 1'b1, 32'h13579BDF};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h208, 32'h0,        4, 32'h2468ACE0, 1'b0, 1'b0, 32'h2468ACE0};
      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // ack while idle must be ignored
      mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
      step();
      mem_ack = 1'b0;
      chk("spur_strobe", {if_valid, dm_valid, mem_req}, 64'd0);
      chk("spur_rdata", {if_rdata, dm_rdata}, {32'h13579BDF, 32'h2468ACE0});
      step();
      chk("spur_after", {if_valid, dm_valid, mem_req}, 64'd0);

      // read withdrawn after grant still completes once
      dm_read = 1'b1; dm_addr = 32'h300;
      step();
      chk("wd_grant", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h300});
      dm_read = 1'b0;
      step();
      chk("wd_hold", mem_req, 64'd1);
      mem_ack = 1'b1; mem_rdata = 32'h5;
      step();
      mem_ack = 1'b0;
      chk("wd_strobe", {dm_valid, dm_rdata}, {1'b1, 32'h5});
      for (int i = 0; i < 2; i++) begin
         step();
         chk("wd_no_reissue", {mem_req, dm_valid}, 64'd0);
      end

      // contention: four data grants, then a forced fetch, then the pattern repeats
      if_req = 1'b1; if_addr = 32'h80; dm_read = 1'b1; dm_addr = 32'h400;
      step();
      for (int i = 0; i < 10; i++) begin
         logic ef;
         ef = ((i % 5) == 4);
         chk($sformatf("cont%0d_addr", i), {mem_req, mem_addr}, {1'b1, ef ? 32'h80 : 32'h400});
         chk($sformatf("cont%0d_cnt", i), 64'(dut.starve_cnt), ef ? 64'd0 : 64'((i % 5) + 1));
         mem_ack = 1'b1; mem_rdata = 32'(i);
         step();
         mem_ack = 1'b0;
         chk($sformatf("cont%0d_strobe", i), {if_valid, dm_valid}, {ef, !ef});
         if (i == 9) begin if_req = 1'b0; dm_read = 1'b0; end
         step();
      end
      chk("cont_idle", mem_req, 64'd0);

      // asynchronous reset in the middle of a data access
      dm_write = 1'b1; dm_addr = 32'h500; dm_wdata = 32'h77;
      step();
      chk("rst_mid_grant", {mem_req, mem_we}, 2'b11);
      #2 reset_n = 1'b0;
      #1;
      chk_reset("rst_mid");
      dm_write = 1'b0; if_req = 1'b1; if_addr = 32'h60;
      #1 reset_n = 1'b1;
      step();
      chk("rst_post_grant", {mem_req, mem_we, mem_addr, stall_if}, {2'b10, 32'h60, 1'b1});
      mem_ack = 1'b1; mem_rdata = 32'hABCD;
      step();
      mem_ack = 1'b0; if_req = 1'b0;
      chk("rst_post_done", {if_valid, if_rdata}, {1'b1, 32'hABCD});
      step();

      // randomized phase with reference model
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      m_busy = 0; m_cnt = 0; e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
      e_ifr = 0; e_dmr = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         step();
         dreq = dm_read | dm_write;
         e_ifv = 1'b0; e_dmv = 1'b0;
         if (m_busy != 0) begin
            if (mem_ack) begin
               if (m_busy == 2) begin
                  e_ifv = 1'b1; e_ifr = mem_rdata;
               end else begin
                  e_dmv = 1'b1;
                  if (!e_we) e_dmr = mem_rdata;
               end
               m_busy = 0; e_req = 1'b0;
            end
         end else if (dreq || if_req) begin
            take_if = if_req && (!dreq || m_cnt == SMAX);
            e_req = 1'b1;
            if (take_if) begin
               m_busy = 2; e_we = 1'b0; e_addr = if_addr; m_cnt = 0;
            end else begin
               m_busy = 1; e_we = dm_write; e_addr = dm_addr; e_wdata = dm_wdata;
               m_cnt = if_req ? ((m_cnt < SMAX) ? m_cnt + 1 : SMAX) : 0;
            end
         end
         e_sif = if_req && !e_ifv;
         e_smem = dreq && !e_dmv;

         chk($sformatf("rnd%0d_ctl", cyc), {mem_req, if_valid, dm_valid, stall_if, stall_mem},
             {e_req, e_ifv, e_dmv, e_sif, e_smem});
         if (e_req) chk($sformatf("rnd%0d_addr", cyc), {mem_we, mem_addr}, {e_we, e_addr});
         if (e_req && e_we) chk($sformatf("rnd%0d_wdata", cyc), mem_wdata, e_wdata);
         chk($sformatf("rnd%0d_rdata", cyc), {if_rdata, dm_rdata}, {e_ifr, e_dmr});
         chk($sformatf("rnd%0d_cnt", cyc), 64'(dut.starve_cnt), 64'(m_cnt));

         // requesters: hold until strobe, occasionally withdraw
         if (!if_req) begin
            if ($urandom_range(0, 2) == 0) begin if_req = 1'b1; if_addr = $urandom; end
         end else if (if_valid) begin
            if_req = 1'($urandom_range(0, 1)); if_addr = $urandom;
         end else if ($urandom_range(0, 40) == 0) begin
            if_req = 1'b0;
         end
         if (!(dm_read | dm_write)) begin
            if ($urandom_range(0, 1) == 0) begin
               case ($urandom_range(0, 2))
                  0: begin dm_read = 1'b1; dm_write = 1'b0; end
                  1: begin dm_read = 1'b0; dm_write = 1'b1; end
                  default: begin dm_read = 1'b1; dm_write = 1'b1; end
               endcase
               dm_addr = $urandom; dm_wdata = $urandom;
            end
         end else if (dm_valid || $urandom_range(0, 40) == 0) begin
            dm_read = 1'b0; dm_write = 1'b0;
         end
         mem_ack = mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
         mem_rdata = $urandom;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
